// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the hex display arbiter.
//   state_e : arbiter FSM states (IDLE / WRITE / DWELL)
//   DISP_W  : width of one display word
package hex_display_arbiter_pkg;

    localparam int DISP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

endpackage

// File: rtl/hex_display_arbiter_rr.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   ptr    : index with highest priority this round
//   winner : first asserted index at or after ptr, wrapping modulo NUM_REQ
//   valid  : 1 when any request is asserted
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] idx;

    // Scan from the farthest position back towards ptr so the nearest
    // asserted request (in rotation order) is the last one to overwrite.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the 8-digit hex display between NUM_REQ requesters.
// Round-robin grant, one-cycle write strobe + word, then a fixed dwell
// time before the next arbitration.
//   iCLOCK / iRESET_N : clock, async active-low reset
//   iREQ              : per-requester level request
//   iDATA             : requester k word at iDATA[32k +: 32]
//   oACK              : one-cycle one-hot acknowledge of the grant
//   oWR / oDATA       : display register write strobe and word
//   oOWNER            : index of last granted requester
//   oBUSY             : high while in WRITE or DWELL
module hex_display_arbiter
    import hex_display_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                      iCLOCK,
    input  logic                      iRESET_N,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [DISP_W*NUM_REQ-1:0] iDATA,
    output logic [NUM_REQ-1:0]        oACK,
    output logic                      oWR,
    output logic [DISP_W-1:0]         oDATA,
    output logic [IDX_W-1:0]          oOWNER,
    output logic                      oBUSY
);

    localparam int               CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 wr_q, wr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DISP_W-1:0]    data_q, data_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 busy_q, busy_d;

    logic [IDX_W-1:0]     win;
    logic                 win_vld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req    (iREQ),
        .ptr    (ptr_q),
        .winner (win),
        .valid  (win_vld)
    );

    // Outputs are registered from next-state values, so a grant taken at
    // the IDLE edge shows up on oWR/oACK during the WRITE cycle itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wr_d    = 1'b0;
        ack_d   = '0;
        data_d  = data_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_WRITE;
                    wr_d       = 1'b1;
                    ack_d[win] = 1'b1;
                    data_d     = iDATA[win*DISP_W +: DISP_W];
                    owner_d    = win;
                end
            end
            ST_WRITE: begin
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = ST_DWELL;
            end
            ST_DWELL: begin
                // Requests are ignored here; counter stops at zero.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign oWR    = wr_q;
    assign oACK   = ack_q;
    assign oDATA  = data_q;
    assign oOWNER = owner_q;
    assign oBUSY  = busy_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
module tb_hex_display_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   ack;
    logic         wr;
    logic [31:0]  odata;
    logic [1:0]   owner;
    logic         busy;

    logic         rst1_n;
    logic [3:0]   req1;
    logic [127:0] data1;
    logic [3:0]   ack1;
    logic         wr1;
    logic [31:0]  odata1;
    logic [1:0]   owner1;
    logic         busy1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hex_display_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(3)) u_dut (
        .iCLOCK(clk), .iRESET_N(rst_n), .iREQ(req), .iDATA(data),
        .oACK(ack), .oWR(wr), .oDATA(odata), .oOWNER(owner), .oBUSY(busy)
    );

    hex_display_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(1)) u_dut1 (
        .iCLOCK(clk), .iRESET_N(rst1_n), .iREQ(req1), .iDATA(data1),
        .oACK(ack1), .oWR(wr1), .oDATA(odata1), .oOWNER(owner1), .oBUSY(busy1)
    );

    typedef struct {
        logic [3:0]  req;
        logic        wr;
        logic [3:0]  ack;
        logic [31:0] data;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic w, input logic [3:0] a,
                           input logic [31:0] d, input logic [1:0] o, input logic b);
        chk({tag, ".wr"},    32'(wr),    32'(w));
        chk({tag, ".ack"},   32'(ack),   32'(a));
        chk({tag, ".data"},  odata,      d);
        chk({tag, ".owner"}, 32'(owner), 32'(o));
        chk({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    task automatic add(input logic [3:0] r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [1:0] o, input logic b);
        vec_t v;
        v.req = r; v.wr = w; v.ack = a; v.data = d; v.owner = o; v.busy = b;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            req = tbl[i].req;
            step();
            chk_all($sformatf("%s[%0d]", tag, i), tbl[i].wr, tbl[i].ack,
                    tbl[i].data, tbl[i].owner, tbl[i].busy);
        end
        tbl.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] dk;
        logic [3:0]  oh;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        req    = 4'hF;
        req1   = 4'h0;
        data   = '0;
        data1  = '0;

        // 1. reset held with all requests asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("reset[%0d]", i), 1'b0, 4'h0, 32'h0, 2'd0, 1'b0);
        end
        req   = 4'h0;
        rst_n = 1'b1;
        step();
        chk_all("idle_after_reset", 1'b0, 4'h0, 32'h0, 2'd0, 1'b0);

        // 2. single requester 2
        data[64 +: 32] = 32'hDEAD_BEEF;
        add(4'b0100, 1'b1, 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 32'hDEAD_BEEF, 2'd2, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 32'hDEAD_BEEF, 2'd2, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 32'hDEAD_BEEF, 2'd2, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 32'hDEAD_BEEF, 2'd2, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 32'hDEAD_BEEF, 2'd2, 1'b0);
        run_tbl("single");

        // 3. all requesting, held: grants 0,1,2,3,0 five cycles apart
        pulse_reset();
        for (int k = 0; k < 4; k++) data[32*k +: 32] = 32'h1111_1111 * (k + 1);
        for (int g = 0; g < 5; g++) begin
            dk = 32'h1111_1111 * ((g % 4) + 1);
            oh = 4'b0001 << (g % 4);
            add(4'hF, 1'b1, oh, dk, 2'(g % 4), 1'b1);
            for (int d = 0; d < 3; d++) add(4'hF, 1'b0, 4'h0, dk, 2'(g % 4), 1'b1);
            if (g < 4) add(4'hF, 1'b0, 4'h0, dk, 2'(g % 4), 1'b0);
        end
        run_tbl("rotate");

        // 4. capture at grant edge; requester 3 withdraws before its turn
        req = 4'h0;
        pulse_reset();
        data[0  +: 32] = 32'h0000_C0DE;
        data[32 +: 32] = 32'hA1A1_A1A1;
        data[96 +: 32] = 32'hA3A3_A3A3;
        req = 4'b1010;
        step();
        chk_all("cap_grant", 1'b1, 4'b0010, 32'hA1A1_A1A1, 2'd1, 1'b1);
        data[32 +: 32] = 32'hBAD0_BAD0;
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("cap_dwell[%0d]", i), 1'b0, 4'h0, 32'hA1A1_A1A1, 2'd1, 1'b1);
        end
        step();
        chk_all("cap_idle", 1'b0, 4'h0, 32'hA1A1_A1A1, 2'd1, 1'b0);
        step();
        chk_all("wrap_to_0", 1'b1, 4'b0001, 32'h0000_C0DE, 2'd0, 1'b1);
        req = 4'h0;
        for (int i = 0; i < 4; i++) step();

        // 5. reset two cycles into DWELL, pointer must restart at 0
        pulse_reset();
        data[0  +: 32] = 32'h5555_0000;
        data[32 +: 32] = 32'h5555_0001;
        req = 4'b0011;
        step();
        chk_all("rst_mid_grant", 1'b1, 4'b0001, 32'h5555_0000, 2'd0, 1'b1);
        step();
        step();
        chk("rst_mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid_async", 1'b0, 4'h0, 32'h0, 2'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk_all("rst_mid_regrant", 1'b1, 4'b0001, 32'h5555_0000, 2'd0, 1'b1);
        req = 4'h0;

        // 6. DWELL_CYCLES=1, single requester held: strobe every 3 cycles
        data1[0 +: 32] = 32'hC0FF_EE00;
        rst1_n = 1'b1;
        req1   = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("d1_wr[%0d]", i),   32'(wr1),   (i % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("d1_ack[%0d]", i),  32'(ack1),  (i % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("d1_busy[%0d]", i), 32'(busy1), (i % 3 == 2) ? 32'd0 : 32'd1);
            chk($sformatf("d1_data[%0d]", i), odata1, 32'hC0FF_EE00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
